// File: rtl/mem_bridge.sv
// mem_bridge: bridges RV32I-style load/store requests onto a word-wide memory
// port with byte enables. It has one outstanding access at a time (IDLE -> ACCESS
// -> RESP). Misaligned accesses and illegal funct3 codes are answered with an
// error response and never reach memory.
// Optional feature: define MEM_TIMEOUT_EN to abort an access that has waited
// TIMEOUT_CYCLES cycles without mem_ack. The abort is reported as an error.
module mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // A zero timeout would abort every access before memory could answer.
    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state;
    state_t      state_next;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        accept;
    logic        req_legal;
    logic        timeout_hit;
    logic [3:0]  be_pattern;
    logic [31:0] wdata_rep;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign accept = req_valid && (state == IDLE);

    // Legality of the incoming request: known funct3 code and natural alignment.
    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'd0:    req_legal = 1'b1;
            3'd1:    req_legal = !req_addr[0];
            3'd2:    req_legal = (req_addr[1:0] == 2'b00);
            3'd4:    req_legal = !req_we;
            3'd5:    req_legal = !req_we && !req_addr[0];
            default: req_legal = 1'b0;
        endcase
    end

    // Byte-lane enables and replicated store data from the latched request.
    always_comb begin
        be_pattern = 4'b1111;
        wdata_rep  = wdata_q;
        case (funct3_q[1:0])
            2'd0: begin
                be_pattern = 4'b0001 << addr_q[1:0];
                wdata_rep  = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be_pattern = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata_q[15:0]}};
            end
            default: begin
                be_pattern = 4'b1111;
                wdata_rep  = wdata_q;
            end
        endcase
    end

    // Pick the addressed lane from the memory word and extend it to 32 bits.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (funct3_q)
            3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_data = {24'd0, byte_sel};
            3'd5:    load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Count ACCESS cycles spent waiting. The count restarts on every acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ACCESS) && !mem_ack &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Latch the request at acceptance and build the response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (!req_legal) begin
                rsp_rdata_q <= 32'd0;
                rsp_err_q   <= 1'b1;
            end
        end else if (state == ACCESS) begin
            if (mem_ack) begin
                rsp_rdata_q <= we_q ? 32'd0 : load_data;
                rsp_err_q   <= 1'b0;
            end else if (timeout_hit) begin
                rsp_rdata_q <= 32'd0;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and all outputs. Outputs are decoded from the state so that reset clears them at once.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_be     = 4'b0000;
        rsp_valid  = 1'b0;
        rsp_rdata  = 32'd0;
        rsp_err    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                mem_ren   = !we_q;
                mem_wen   = we_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = we_q ? wdata_rep : 32'd0;
                mem_be    = be_pattern;
                if (mem_ack || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = rsp_rdata_q;
                rsp_err    = rsp_err_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed self-checking bench for mem_bridge.
// A transaction-level model predicts every output on every cycle. Literal expectations are also pinned for the reference cases.
// When MEM_TIMEOUT_EN is defined, the timeout abort is exercised as well.
module tb_mem_bridge;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int tests_run;
    int tests_failed;

    logic        check_en;
    logic        exp_ready;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_rsp_valid;
    logic [31:0] exp_rdata;
    logic        exp_err;

    int          cyc;
    int          acc_cyc;
    int          rsp_cyc;
    int          rsp_cnt;
    int          ren_cnt;
    int          wen_cnt;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [3:0]  last_be;
    logic [31:0] last_rdata;
    logic        last_err;

    mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: access width in bytes from the funct3 size field.
    function automatic int m_bytes(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_legal(logic we, logic [2:0] f3, logic [31:0] addr);
        if (we && f3 > 3'd2) return 1'b0;
        if (!we && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b0;
        return (addr % m_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] addr);
        int mask = (1 << m_bytes(f3)) - 1;
        int sh   = mask << (addr % 4);
        return sh[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] wdata);
        logic [31:0] r;
        int nb = m_bytes(f3);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wdata[8*(k % nb) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
        int     nb   = m_bytes(f3);
        int     off  = addr % 4;
        longint mask = (64'd1 << (8 * nb)) - 1;
        longint v    = (longint'(rdata) >> (8 * off)) & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic setIdleExp();
        exp_ready = 1'b1; exp_ren = 1'b0; exp_wen = 1'b0;
        exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0;
        exp_rsp_valid = 1'b0; exp_rdata = 32'd0; exp_err = 1'b0;
    endtask

    // Every cycle: compare all outputs against the model and record activity for the literal pins.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("mem_ren", 32'(mem_ren), 32'(exp_ren));
            checkOutput("mem_wen", 32'(mem_wen), 32'(exp_wen));
            checkOutput("mem_addr", mem_addr, exp_addr);
            checkOutput("mem_wdata", mem_wdata, exp_wdata);
            checkOutput("mem_be", 32'(mem_be), 32'(exp_be));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
            checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
        end
        if (mem_ren) ren_cnt++;
        if (mem_wen) wen_cnt++;
        if (mem_ren || mem_wen) begin
            last_addr = mem_addr; last_wdata = mem_wdata; last_be = mem_be;
        end
        if (rsp_valid) begin
            rsp_cnt++; rsp_cyc = cyc; last_rdata = rsp_rdata; last_err = rsp_err;
        end
    end

    // Run one request through the bridge. The model expectation is set for each cycle.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int waits, input bit noack);
        bit legal = m_legal(we, f3, addr);
        int n;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        setIdleExp();
        acc_cyc = cyc; rsp_cnt = 0; ren_cnt = 0; wen_cnt = 0;
        @(posedge clk); #1;
        req_we = ~we; req_funct3 = f3 ^ 3'b101; req_addr = ~addr; req_wdata = ~wdata;
        exp_ready = 1'b0;
        if (legal) begin
            n = noack ? TMO : waits + 1;
            for (int i = 0; i < n; i++) begin
                mem_ack   = !noack && (i == n - 1);
                mem_rdata = mem_ack ? rdata : ~rdata;
                exp_ren = !we; exp_wen = we;
                exp_addr = addr & ~32'd3; exp_be = m_be(f3, addr);
                exp_wdata = we ? m_wdata(f3, wdata) : 32'd0;
                @(posedge clk); #1;
            end
            exp_err   = noack;
            exp_rdata = (noack || we) ? 32'd0 : m_load(f3, addr, rdata);
        end else begin
            exp_err = 1'b1; exp_rdata = 32'd0;
        end
        exp_ren = 1'b0; exp_wen = 1'b0; exp_addr = 32'd0; exp_wdata = 32'd0; exp_be = 4'd0;
        exp_rsp_valid = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        setIdleExp();
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; cyc = 0; check_en = 1'b0;
        rsp_cnt = 0; ren_cnt = 0; wen_cnt = 0; rsp_cyc = 0; acc_cyc = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        setIdleExp();
        #2;
        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_strobes", 32'({mem_ren, mem_wen}), 32'd0);
        checkOutput("reset_mem_be", 32'(mem_be), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; check_en = 1'b1;
        @(posedge clk); #1;

        // LB at 0x103, acknowledged in the first cycle.
        applyStimulus(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 1'b0);
        checkOutput("lb_be", 32'(last_be), 32'h8);
        checkOutput("lb_rdata", last_rdata, 32'hFFFF_FF80);
        checkOutput("lb_latency", 32'(rsp_cyc - acc_cyc), 32'd2);

        // SH at 0x202 with three wait cycles.
        applyStimulus(1'b1, 3'd1, 32'h202, 32'h0000_BEEF, 32'h0, 3, 1'b0);
        checkOutput("sh_wen_cycles", 32'(wen_cnt), 32'd4);
        checkOutput("sh_addr", last_addr, 32'h200);
        checkOutput("sh_be", 32'(last_be), 32'hC);
        checkOutput("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        checkOutput("sh_err", 32'(last_err), 32'd0);
        checkOutput("sh_latency", 32'(rsp_cyc - acc_cyc), 32'd5);

        // A misaligned LW never touches memory.
        applyStimulus(1'b0, 3'd2, 32'h101, 32'h0, 32'h1111_1111, 0, 1'b0);
        checkOutput("lw_mis_ren", 32'(ren_cnt), 32'd0);
        checkOutput("lw_mis_err", 32'(last_err), 32'd1);
        checkOutput("lw_mis_rdata", last_rdata, 32'd0);
        checkOutput("lw_mis_latency", 32'(rsp_cyc - acc_cyc), 32'd1);

        applyStimulus(1'b0, 3'd5, 32'h2, 32'h0, 32'h8001_0000, 1, 1'b0);
        checkOutput("lhu_rdata", last_rdata, 32'h0000_8001);

        applyStimulus(1'b1, 3'd0, 32'h7, 32'hFFFF_FFA5, 32'h0, 1, 1'b0);
        checkOutput("sb_wdata", last_wdata, 32'hA5A5_A5A5);
        checkOutput("sb_be", 32'(last_be), 32'h8);

        applyStimulus(1'b0, 3'd1, 32'h6, 32'h0, 32'h9ABC_0000, 2, 1'b0);
        checkOutput("lh_rdata", last_rdata, 32'hFFFF_9ABC);

        applyStimulus(1'b0, 3'd4, 32'h5, 32'h0, 32'h0000_F000, 0, 1'b0);
        checkOutput("lbu_rdata", last_rdata, 32'h0000_00F0);

        applyStimulus(1'b1, 3'd2, 32'h10, 32'h1234_5678, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 3'd2, 32'h8, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        applyStimulus(1'b1, 3'd3, 32'h0, 32'h5555_5555, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 3'd6, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 3'd1, 32'h3, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 3'd1, 32'h201, 32'hAAAA, 32'h0, 0, 1'b0);
        checkOutput("sh_mis_wen", 32'(wen_cnt), 32'd0);
        req_valid = 1'b0;

        // An ack in IDLE is ignored.
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;

        // Reset asserted in the middle of an access.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ready = 1'b0; exp_ren = 1'b1; exp_addr = 32'h40; exp_be = 4'hF;
        @(posedge clk); #1;
        check_en = 1'b0; rsp_cnt = 0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ren", 32'(mem_ren), 32'd0);
        checkOutput("rst_mid_be", 32'(mem_be), 32'd0);
        checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        setIdleExp(); check_en = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_no_rsp", 32'(rsp_cnt), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);

`ifdef MEM_TIMEOUT_EN
        applyStimulus(1'b0, 3'd2, 32'h80, 32'h0, 32'h0, 0, 1'b1);
        checkOutput("tmo_ren_cycles", 32'(ren_cnt), 32'd4);
        checkOutput("tmo_err", 32'(last_err), 32'd1);
        checkOutput("tmo_rdata", last_rdata, 32'd0);
        req_valid = 1'b0;
`endif

        // A normal access still works after the reset.
        applyStimulus(1'b0, 3'd0, 32'h1, 32'h0, 32'h0000_7F00, 0, 1'b0);
        checkOutput("post_rst_lb", last_rdata, 32'h0000_007F);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
